re_expander32: RTL and testbench
================================

RE_EXPANDER32 -- requirements
Module: re_expander32

Interface
REQ-001 SHALL have parameter NUM_LENGTH, default 32, giving the reconstructed number width.
REQ-002 SHALL have parameter K_LENGTH, default 5, giving the leading-one position width.
REQ-003 SHALL have parameter M1_LENGTH, default 16, giving the mantissa width (MSB-first bits below the leading one), with 1 <= M1_LENGTH <= 31.
REQ-004 SHALL have the ports below, one clock, reset asynchronous and active-low:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  block accepts a request.
- in_k  in  K_LENGTH  leading-one position, 0..31.
- in_m1  in  M1_LENGTH  mantissa bits.
- in_zero  in  1  request encodes value 0.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes result.
- num  out  NUM_LENGTH  reconstructed number.
- busy  out  1  high in any state other than IDLE.

Function
REQ-005 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-006 SHALL drive in_ready=1 only in IDLE; a request is accepted on a rising edge where in_valid&in_ready=1.
REQ-007 On acceptance, SHALL load the working register W = {1'b1, in_m1, (31-M1_LENGTH) zeros}, latch in_k and in_zero, clear the stage counter, and go to SHIFT.
REQ-008 In SHIFT, SHALL apply one stage per cycle in the order 16, 8, 4, 2, 1; at each stage, if the corresponding in_k bit (4..0) is 0, W is logically right-shifted by that amount, otherwise it is held.
REQ-009 SHALL therefore produce W >> (31-k) after exactly 5 SHIFT cycles; bits shifted below bit 0 are discarded.
REQ-010 After the 5th stage edge, SHALL enter DONE with out_valid=1; latency is 5 cycles from the acceptance edge to out_valid high.
REQ-011 In DONE, SHALL hold num = (latched in_zero ? 0 : W) and out_valid stable until out_ready=1.
REQ-012 On the edge where out_valid&out_ready=1, SHALL return to IDLE with out_valid=0; the next request is accepted no earlier than the following edge, giving a minimum throughput of 1 result per 7 cycles.
REQ-013 SHALL ignore in_valid, in_k, in_m1 and in_zero while in SHIFT or DONE; latched values SHALL NOT change.
REQ-014 in_zero=1 SHALL force num=0 regardless of in_k and in_m1; the SHIFT sequence still runs, so latency is unchanged.
REQ-015 k=31 SHALL yield no shift; k=0 with in_zero=0 SHALL yield num=1.
REQ-016 out_ready asserted outside DONE SHALL have no effect.
REQ-017 num SHALL be 0 in every state except DONE.

Reset
REQ-018 rst_n=0 SHALL immediately force state IDLE, W=0, stage counter=0, latched fields=0, out_valid=0, busy=0, num=0, and in_ready=1 once rst_n=1.
REQ-019 Reset asserted during SHIFT or DONE SHALL abort the operation; no out_valid pulse SHALL follow, and the first edge after release SHALL be able to accept a new request.

Configuration
REQ-020 The macro RE_EXPAND_ROUND_EN SHALL control midpoint compensation; a configuration that does not define it SHALL have no compensation.
REQ-021 With RE_EXPAND_ROUND_EN defined and M1_LENGTH < 31, the load SHALL additionally set W bit (30-M1_LENGTH) to 1, the midpoint of the truncated interval.
REQ-022 With RE_EXPAND_ROUND_EN undefined, the bits below the mantissa SHALL be zero.
REQ-023 Under either setting, in_zero SHALL still give num=0, and latency SHALL be unchanged.

Verification
REQ-024 k=31, m1=0xFFFF, zero=0, out_ready=1 -> out_valid 5 cycles after accept, num=0xFFFF8000 (0xFFFFC000 with RE_EXPAND_ROUND_EN).
REQ-025 k=4, m1=0xA000 -> num=26 (0x1A) in both configurations; k=0, m1=0x1234 -> num=1.
REQ-026 in_zero=1, k=17, m1=0xFFFF -> num=0 with the same 5-cycle latency.
REQ-027 out_ready=0 for 10 cycles in DONE, new in_valid pulses applied -> num/out_valid stable, in_ready=0, no second request accepted; out_ready=1 -> IDLE next edge.
REQ-028 rst_n pulsed low at SHIFT stage 3 -> all outputs 0 immediately, no out_valid afterwards, next request k=8, m1=0x8000 -> num=0x180.

Source files
------------

// File: rtl/re_expander32.sv
// ----------------------------------------------------------------------------
// re_expander32
//
// Rebuilds a NUM_LENGTH-bit integer from a leading-one position k and the
// MSB-first mantissa bits that follow the leading one.  The working register
// is loaded as {1, m1, zeros} (the leading one sits in the MSB) and is then
// moved down by (31 - k) through five conditional shift stages
// (16, 8, 4, 2, 1), one stage per clock.  The result is held until the
// consumer takes it.
//
// Optional feature (compile-time macro RE_EXPAND_ROUND_EN):
//   When defined, the bit directly below the mantissa is set on load.  This
//   places the truncated tail at the midpoint of its interval instead of at
//   its floor.  When undefined, the bits below the mantissa are zero.
//
// Ports:
//   clk        in   1            rising-edge clock
//   rst_n      in   1            asynchronous active-low reset
//   in_valid   in   1            request present
//   in_ready   out  1            block accepts a request (IDLE only)
//   in_k       in   K_LENGTH     leading-one position, 0..31
//   in_m1      in   M1_LENGTH    mantissa bits below the leading one
//   in_zero    in   1            request encodes the value 0
//   out_valid  out  1            result held (DONE)
//   out_ready  in   1            consumer takes the result
//   num        out  NUM_LENGTH   reconstructed number, 0 outside DONE
//   busy       out  1            high in any state other than IDLE
// ----------------------------------------------------------------------------
module re_expander32 #(
    parameter int NUM_LENGTH = 32,
    parameter int K_LENGTH   = 5,
    parameter int M1_LENGTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [K_LENGTH-1:0]   in_k,
    input  logic [M1_LENGTH-1:0]  in_m1,
    input  logic                  in_zero,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NUM_LENGTH-1:0] num,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Midpoint bit position; only meaningful when the mantissa leaves at
    // least one bit free below it.
    localparam bit RND_FITS = (M1_LENGTH < NUM_LENGTH - 1);
    localparam int RND_BIT  = RND_FITS ? (NUM_LENGTH - 2 - M1_LENGTH) : 0;

    localparam logic [2:0] LAST_STAGE = 3'd4;

    state_t                  state_q, state_d;
    logic [NUM_LENGTH-1:0]   w_q, w_d;
    logic [K_LENGTH-1:0]     k_q, k_d;
    logic                    zero_q, zero_d;
    logic [2:0]              stage_q, stage_d;

    // Working-register image at acceptance: leading one in the MSB, the
    // mantissa directly below it, then the (optionally compensated) tail.
    function automatic logic [NUM_LENGTH-1:0] load_word(
        input logic [M1_LENGTH-1:0] m1
    );
        logic [NUM_LENGTH-1:0] w;
        w                            = '0;
        w[NUM_LENGTH-1]              = 1'b1;
        w[NUM_LENGTH-2 -: M1_LENGTH] = m1;
`ifdef RE_EXPAND_ROUND_EN
        if (RND_FITS) begin
            w[RND_BIT] = 1'b1;
        end
`endif
        return w;
    endfunction

    // One stage of the barrel: stage 0..4 tests k bit 4..0 and shifts by
    // 16..1 when that bit is clear.  Across all five stages this yields a
    // total shift of (31 - k).
    function automatic logic [NUM_LENGTH-1:0] apply_stage(
        input logic [NUM_LENGTH-1:0] w,
        input logic [2:0]            stage,
        input logic [K_LENGTH-1:0]   k
    );
        logic [NUM_LENGTH-1:0] r;
        r = w;
        case (stage)
            3'd0: if (!k[4]) r = w >> 16;
            3'd1: if (!k[3]) r = w >> 8;
            3'd2: if (!k[2]) r = w >> 4;
            3'd3: if (!k[1]) r = w >> 2;
            3'd4: if (!k[0]) r = w >> 1;
            default: r = w;
        endcase
        return r;
    endfunction

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            w_q     <= '0;
            k_q     <= '0;
            zero_q  <= 1'b0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            k_q     <= k_d;
            zero_q  <= zero_d;
            stage_q <= stage_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        k_d     = k_q;
        zero_d  = zero_q;
        stage_d = stage_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    w_d     = load_word(in_m1);
                    k_d     = in_k;
                    zero_d  = in_zero;
                    stage_d = '0;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                w_d = apply_stage(w_q, stage_q, k_q);
                if (stage_q == LAST_STAGE) begin
                    stage_d = '0;
                    state_d = DONE;
                end else begin
                    stage_d = stage_q + 3'd1;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // in_ready is gated by rst_n so that every output reads 0 while reset
    // is held, and goes high as soon as reset is released.
    always_comb begin
        in_ready  = (state_q == IDLE) && rst_n;
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        num       = '0;
        if ((state_q == DONE) && !zero_q) begin
            num = w_q;
        end
    end

endmodule

// File: tb/tb_re_expander32.sv
module tb_re_expander32;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_k;
    logic [15:0] in_m1;
    logic        in_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] num;
    logic        busy;

    int errs;
    int checks;

    re_expander32 #(
        .NUM_LENGTH(32),
        .K_LENGTH  (5),
        .M1_LENGTH (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_k     (in_k),
        .in_m1    (in_m1),
        .in_zero  (in_zero),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .num      (num),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, req);
        end
    endtask

    // Reference: the value is 1.m1 (binary fixed point) scaled by 2^k and
    // truncated to an integer.  With compensation, an extra half-LSB of the
    // mantissa is added before scaling.
    function automatic logic [31:0] model(input int k, input logic [15:0] m1, input bit z);
        longint unsigned frac;
        if (z) return 32'd0;
        frac = 64'h1_0000 + 64'(m1);        // 1.m1 scaled by 2^16
        frac = frac * 2;                    // one extra bit of resolution
`ifdef RE_EXPAND_ROUND_EN
        frac = frac + 1;                    // midpoint of the truncated tail
`endif
        // value = frac * 2^k / 2^17
        return 32'((frac << k) >> 17);
    endfunction

    // Issue one request, measure its latency, optionally stall the consumer
    // for 'hold' cycles while poking the inputs, then release it.
    task automatic run_txn(input int k, input logic [15:0] m1, input bit z, input int hold,
                           input string tag);
        logic [31:0] req;
        logic [31:0] held;
        int lat;
        req = model(k, m1, z);

        @(negedge clk);
        check({tag, "_rdy_idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_k     = 5'(k);
        in_m1    = m1;
        in_zero  = z;

        @(negedge clk);
        // Accepted on the last edge; inputs changing now must be ignored.
        in_valid = 1'($urandom);
        in_k     = 5'($urandom);
        in_m1    = 16'($urandom);
        in_zero  = 1'($urandom);
        out_ready = 1'($urandom);
        check({tag, "_rdy_busy"}, 32'(in_ready), 32'd0);
        check({tag, "_num_shift"}, num, 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
            in_valid  = 1'($urandom);
            in_k      = 5'($urandom);
            in_m1     = 16'($urandom);
            in_zero   = 1'($urandom);
            out_ready = 1'($urandom);
        end
        check({tag, "_latency"}, 32'(lat), 32'd5);
        check({tag, "_num"}, num, req);

        held = num;
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_k      = 5'($urandom);
            in_m1     = 16'($urandom);
            in_zero   = 1'($urandom);
            @(negedge clk);
            check({tag, "_hold_num"}, num, held);
            check({tag, "_hold_vld"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
        end

        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_ret_vld"}, 32'(out_valid), 32'd0);
        check({tag, "_ret_num"}, num, 32'd0);
        check({tag, "_ret_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        errs      = 0;
        checks    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_k      = '0;
        in_m1     = '0;
        in_zero   = 1'b0;
        out_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_vld", 32'(out_valid), 32'd0);
        check("rst_num", num, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_rdy", 32'(in_ready), 32'd1);

        // Directed corners
`ifdef RE_EXPAND_ROUND_EN
        check("model_k31", model(31, 16'hFFFF, 1'b0), 32'hFFFFC000);
`else
        check("model_k31", model(31, 16'hFFFF, 1'b0), 32'hFFFF8000);
`endif
        run_txn(31, 16'hFFFF, 1'b0, 0, "k31");
        run_txn(4,  16'hA000, 1'b0, 0, "k4");
        run_txn(0,  16'h1234, 1'b0, 0, "k0");
        run_txn(17, 16'hFFFF, 1'b1, 0, "zero");
        run_txn(12, 16'h5A5A, 1'b0, 10, "stall");

        // Randomized requests
        for (int n = 0; n < 40; n++) begin
            run_txn(int'($urandom_range(0, 31)), 16'($urandom), ($urandom_range(0, 7) == 0),
                    int'($urandom_range(0, 3)), "rnd");
        end

        // Reset in the middle of SHIFT
        @(negedge clk);
        in_valid = 1'b1;
        in_k     = 5'd20;
        in_m1    = 16'hFFFF;
        in_zero  = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_vld", 32'(out_valid), 32'd0);
        check("abort_num", num, 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rdy", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_no_vld", 32'(out_valid), 32'd0);
        end
        run_txn(8, 16'h8000, 1'b0, 0, "post_rst");
        check("model_k8", model(8, 16'h8000, 1'b0), 32'h00000180);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
